// File: rtl/branch_predictor_pkg.sv
// Shared types, reset constants and helpers for the dynamic branch predictor.
package branch_predictor_pkg;

  localparam int         BP_INDEX_BITS = 6;
  localparam logic [1:0] BP_CNT_INIT   = 2'b01;

  // In-flight payload below the table index: predicted direction, target, pc.
  typedef struct packed {
    logic        dir;
    logic [31:0] target;
    logic [31:0] pc;
  } bp_payload_t;

  function automatic int bp_entry_w(input int index_bits);
    return index_bits + 1 + 32 + 32;
  endfunction

  function automatic logic [1:0] bp_train(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    r = c;
    if (taken && c != 2'b11)       r = c + 2'd1;
    else if (!taken && c != 2'b00) r = c - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// Depth-2 in-order FIFO of predictions awaiting resolution; clear empties it at the edge.
module bp_inflight_fifo #(
  parameter int W = 71
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_q, wr_d, rd_q, rd_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear) begin
      wr_d  = 1'b0;
      rd_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      // Push into a full FIFO only happens alongside a pop; the head is consumed this cycle.
      if (push) begin
        mem_d[wr_q] = din;
        wr_d        = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter direction predictor with in-flight tracking,
// mispredict redirect and perf counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        flush,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  input  logic [31:0] pred_target,
  output logic        pred_ready,
  output logic        pred_taken,
  input  logic        res_valid,
  input  logic        res_taken,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt,
  output logic        res_err
);

  localparam int NENT = 1 << INDEX_BITS;
  localparam int EW   = bp_entry_w(INDEX_BITS);
  localparam int PW   = $bits(bp_payload_t);

  logic [NENT-1:0][1:0] cnt_q, cnt_d;
  logic                 mispredict_q, mispredict_d;
  logic [31:0]          redirect_q, redirect_d;
  logic [31:0]          branch_cnt_q, branch_cnt_d;
  logic [31:0]          mispred_cnt_q, mispred_cnt_d;
  logic                 res_err_q, res_err_d;

  logic [INDEX_BITS-1:0] pred_idx, head_idx;
  logic [EW-1:0]         push_data, head_data;
  bp_payload_t           push_pl, head_pl;
  logic [1:0]            fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop, clear;

  assign pred_idx   = pred_pc[INDEX_BITS+1:2];
  assign pred_taken = cnt_q[pred_idx][1];
  assign pred_ready = !fifo_full || res_valid;

  assign push_pl   = '{dir: pred_taken, target: pred_target, pc: pred_pc};
  assign push_data = {pred_idx, push_pl};
  assign head_idx  = head_data[EW-1 -: INDEX_BITS];
  assign head_pl   = bp_payload_t'(head_data[PW-1:0]);

  // flush squashes the resolve too, so it never trains the table or bumps perf counters.
  assign pop   = res_valid && (fifo_count != 2'd0) && !flush;
  assign push  = pred_valid && pred_ready && !stall && !flush && !mispredict_d;
  assign clear = flush || mispredict_d;

  always_comb begin
    cnt_d         = cnt_q;
    mispredict_d  = 1'b0;
    redirect_d    = redirect_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    res_err_d     = res_err_q || (res_valid && fifo_empty);
    if (pop) begin
      cnt_d[head_idx] = bp_train(cnt_q[head_idx], res_taken);
      branch_cnt_d    = branch_cnt_q + 32'd1;
      if (res_taken != head_pl.dir) begin
        mispredict_d  = 1'b1;
        mispred_cnt_d = mispred_cnt_q + 32'd1;
        // Not-taken resumes past the delay slot.
        redirect_d    = res_taken ? head_pl.target : head_pl.pc + 32'd8;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q         <= {NENT{BP_CNT_INIT}};
      mispredict_q  <= 1'b0;
      redirect_q    <= 32'd0;
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
      res_err_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      mispredict_q  <= mispredict_d;
      redirect_q    <= redirect_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      res_err_q     <= res_err_d;
    end
  end

  bp_inflight_fifo #(.W(EW)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .push   (push),
    .pop    (pop),
    .din    (push_data),
    .dout   (head_data),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
  assign res_err     = res_err_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: training, saturation, redirect, FIFO limits, flush, reset.
module tb_branch_predictor;

  logic        clk = 1'b0, resetn = 1'b0, stall = 1'b0, flush = 1'b0;
  logic        pred_valid = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
  logic [31:0] pred_pc = 32'd0, pred_target = 32'd0;
  logic        pred_ready, pred_taken, mispredict, res_err;
  logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

  int checks = 0, failures = 0;

  localparam logic [31:0] PC_A = 32'h0040_0010, TG_A = 32'h0040_0100;
  localparam logic [31:0] PC_B = 32'h0040_0020, TG_B = 32'h0040_0200;
  localparam logic [31:0] PC_C = 32'h0040_0030, TG_C = 32'h0040_0300;

  branch_predictor dut (
    .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_target(pred_target),
    .pred_ready(pred_ready), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_taken(res_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt), .res_err(res_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    pred_valid = 1'b0; res_valid = 1'b0; res_taken = 1'b0; flush = 1'b0; stall = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic drive_pred(input logic [31:0] pc, input logic [31:0] tg);
    pred_valid = 1'b1; pred_pc = pc; pred_target = tg;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      pred_pc = 32'(i) << 2; #1;
      checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred idx=%0d got=%b want=0", i, pred_taken); end
    end
    checks++; if (pred_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", pred_ready); end
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL reset_mp got=%b want=0", mispredict); end
    checks++; if (redirect_pc !== 32'd0) begin failures++; $display("FAIL reset_redir got=%h want=0", redirect_pc); end
    checks++; if (branch_cnt !== 32'd0) begin failures++; $display("FAIL reset_bcnt got=%0d want=0", branch_cnt); end
    checks++; if (mispred_cnt !== 32'd0) begin failures++; $display("FAIL reset_mcnt got=%0d want=0", mispred_cnt); end
    checks++; if (res_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", res_err); end
  endtask

  // Counter at A goes 01 -> 10 after one taken resolve.
  task automatic test_mispredict_taken();
    drive_pred(PC_A, TG_A); #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL mt_first_pred got=%b want=0", pred_taken); end
    step();
    idle(); res_valid = 1'b1; res_taken = 1'b1;
    step();
    res_valid = 1'b0;
    checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL mt_pulse got=%b want=1", mispredict); end
    checks++; if (redirect_pc !== TG_A) begin failures++; $display("FAIL mt_redir got=%h want=%h", redirect_pc, TG_A); end
    checks++; if (mispred_cnt !== 32'd1) begin failures++; $display("FAIL mt_mcnt got=%0d want=1", mispred_cnt); end
    checks++; if (branch_cnt !== 32'd1) begin failures++; $display("FAIL mt_bcnt got=%0d want=1", branch_cnt); end
    pred_pc = PC_A; #1;
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL mt_trained got=%b want=1", pred_taken); end
    step();
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL mt_pulse_end got=%b want=0", mispredict); end
    checks++; if (redirect_pc !== TG_A) begin failures++; $display("FAIL mt_redir_hold got=%h want=%h", redirect_pc, TG_A); end
  endtask

  // Continues from counter=2 at A: five taken (sat 3), then two not-taken (2, then 1).
  task automatic test_saturate();
    for (int k = 0; k < 5; k++) begin
      drive_pred(PC_A, TG_A); #1;
      checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL sat_pred k=%0d got=%b want=1", k, pred_taken); end
      step();
      idle(); res_valid = 1'b1; res_taken = 1'b1;
      step();
      res_valid = 1'b0;
      checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL sat_mp k=%0d got=%b want=0", k, mispredict); end
    end
    checks++; if (branch_cnt !== 32'd6) begin failures++; $display("FAIL sat_bcnt got=%0d want=6", branch_cnt); end
    for (int k = 0; k < 2; k++) begin
      drive_pred(PC_A, TG_A); step();
      idle(); res_valid = 1'b1; res_taken = 1'b0;
      step();
      res_valid = 1'b0; pred_pc = PC_A; #1;
      checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL nt_mp k=%0d got=%b want=1", k, mispredict); end
      checks++; if (redirect_pc !== 32'h0040_0018) begin failures++; $display("FAIL nt_redir k=%0d got=%h want=00400018", k, redirect_pc); end
      checks++; if (mispred_cnt !== 32'(2 + k)) begin failures++; $display("FAIL nt_mcnt k=%0d got=%0d want=%0d", k, mispred_cnt, 2 + k); end
      checks++; if (branch_cnt !== 32'(7 + k)) begin failures++; $display("FAIL nt_bcnt k=%0d got=%0d want=%0d", k, branch_cnt, 7 + k); end
      checks++; if (pred_taken !== (k == 0)) begin failures++; $display("FAIL nt_pred k=%0d got=%b want=%b", k, pred_taken, k == 0); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_pred(PC_B, TG_B);
    step(); step(); #1;
    checks++; if (pred_ready !== 1'b0) begin failures++; $display("FAIL bb_full_ready got=%b want=0", pred_ready); end
    res_valid = 1'b1; res_taken = 1'b0; #1;
    checks++; if (pred_ready !== 1'b1) begin failures++; $display("FAIL bb_popready got=%b want=1", pred_ready); end
    step();
    res_valid = 1'b0; #1;
    checks++; if (branch_cnt !== 32'd1) begin failures++; $display("FAIL bb_bcnt1 got=%0d want=1", branch_cnt); end
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL bb_mp got=%b want=0", mispredict); end
    checks++; if (pred_ready !== 1'b0) begin failures++; $display("FAIL bb_still_full got=%b want=0", pred_ready); end
    step();
    idle(); res_valid = 1'b1;
    step(); step();
    checks++; if (branch_cnt !== 32'd3) begin failures++; $display("FAIL bb_drain_bcnt got=%0d want=3", branch_cnt); end
    checks++; if (res_err !== 1'b0) begin failures++; $display("FAIL bb_err_early got=%b want=0", res_err); end
    step();
    res_valid = 1'b0;
    checks++; if (res_err !== 1'b1) begin failures++; $display("FAIL bb_err got=%b want=1", res_err); end
    checks++; if (branch_cnt !== 32'd3) begin failures++; $display("FAIL bb_err_bcnt got=%0d want=3", branch_cnt); end
  endtask

  task automatic test_mispredict_clear();
    do_reset();
    drive_pred(PC_A, TG_A); step();
    drive_pred(PC_B, TG_B); step();
    drive_pred(PC_C, TG_C); res_valid = 1'b1; res_taken = 1'b1;
    step();
    idle();
    checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL mc_mp got=%b want=1", mispredict); end
    checks++; if (redirect_pc !== TG_A) begin failures++; $display("FAIL mc_redir got=%h want=%h", redirect_pc, TG_A); end
    res_valid = 1'b1; res_taken = 1'b0;
    step();
    idle();
    checks++; if (res_err !== 1'b1) begin failures++; $display("FAIL mc_err got=%b want=1", res_err); end
    checks++; if (branch_cnt !== 32'd1) begin failures++; $display("FAIL mc_bcnt got=%0d want=1", branch_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    drive_pred(PC_A, TG_A); step();
    drive_pred(PC_B, TG_B); flush = 1'b1;
    step();
    idle(); res_valid = 1'b1; res_taken = 1'b1;
    step();
    idle(); pred_pc = PC_A; #1;
    checks++; if (res_err !== 1'b1) begin failures++; $display("FAIL fl_err got=%b want=1", res_err); end
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL fl_mp got=%b want=0", mispredict); end
    checks++; if (branch_cnt !== 32'd0) begin failures++; $display("FAIL fl_bcnt got=%0d want=0", branch_cnt); end
    checks++; if (mispred_cnt !== 32'd0) begin failures++; $display("FAIL fl_mcnt got=%0d want=0", mispred_cnt); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL fl_table got=%b want=0", pred_taken); end
  endtask

  task automatic test_stall();
    do_reset();
    drive_pred(PC_A, TG_A); stall = 1'b1;
    step();
    idle(); res_valid = 1'b1; res_taken = 1'b1;
    step();
    idle();
    checks++; if (res_err !== 1'b1) begin failures++; $display("FAIL st_err got=%b want=1", res_err); end
    checks++; if (branch_cnt !== 32'd0) begin failures++; $display("FAIL st_bcnt got=%0d want=0", branch_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_pred(PC_A, TG_A); step();
    idle(); res_valid = 1'b1; res_taken = 1'b1;
    step();
    idle(); pred_pc = PC_A; #1;
    checks++; if (mispredict !== 1'b1) begin failures++; $display("FAIL ar_pre_mp got=%b want=1", mispredict); end
    resetn = 1'b0; #1;
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL ar_mp got=%b want=0", mispredict); end
    checks++; if (redirect_pc !== 32'd0) begin failures++; $display("FAIL ar_redir got=%h want=0", redirect_pc); end
    checks++; if (branch_cnt !== 32'd0) begin failures++; $display("FAIL ar_bcnt got=%0d want=0", branch_cnt); end
    checks++; if (mispred_cnt !== 32'd0) begin failures++; $display("FAIL ar_mcnt got=%0d want=0", mispred_cnt); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL ar_table got=%b want=0", pred_taken); end
    checks++; if (pred_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b want=1", pred_ready); end
    step();
    resetn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_mispredict_taken();
    test_saturate();
    test_back_to_back();
    test_mispredict_clear();
    test_flush();
    test_stall();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
